// File: rtl/axi_modport_slave.sv
// AXI3 slave backed by a byte-addressed word memory; one outstanding write and one outstanding
// read, each handled by its own FSM so the two channel pairs run concurrently.
module axi_modport_slave #(
    parameter int unsigned ID_W      = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    // write address
    input  logic [ID_W-1:0]     AWID,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [3:0]          AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    // write data
    input  logic [ID_W-1:0]     WID,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    // write response
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    // read address
    input  logic [ID_W-1:0]     ARID,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [3:0]          ARLEN,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic                ARVALID,
    output logic                ARREADY,
    // read data
    output logic [ID_W-1:0]     RID,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LANE_W = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(MEM_WORDS);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstWrap  = 2'b10;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic {RIdle, RData} r_state_e;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [3:0]        len,
                                                    input logic [2:0]        size,
                                                    input logic [1:0]        burst);
        logic [ADDR_W-1:0] incr;
        logic [ADDR_W-1:0] mask;
        incr = ADDR_W'(1) << size;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        case (burst)
            BurstFixed: next_addr = addr;
            BurstWrap:  next_addr = (addr & ~mask) | ((addr + incr) & mask);
            default:    next_addr = addr + incr;
        endcase
    endfunction

    function automatic logic burst_err(input logic [ADDR_W-1:0] addr,
                                       input logic [3:0]        len,
                                       input logic [2:0]        size,
                                       input logic [1:0]        burst);
        logic [ADDR_W-1:0] incr;
        logic              err;
        incr = ADDR_W'(1) << size;
        err  = (burst == 2'b11) || (size > 3'd2);
        if (burst == BurstWrap) begin
            if (!(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) err = 1'b1;
            if ((addr & (incr - ADDR_W'(1))) != '0) err = 1'b1;
        end
        return err;
    endfunction

    logic [DATA_W-1:0] mem_q [MEM_WORDS];

    // ---------------------------------------------------------------- write side
    w_state_e          w_state_q, w_state_d;
    logic [ID_W-1:0]   w_id_q, w_id_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [3:0]        w_len_q, w_len_d;
    logic [2:0]        w_size_q, w_size_d;
    logic [1:0]        w_burst_q, w_burst_d;
    logic [3:0]        w_cnt_q, w_cnt_d;
    logic              w_derr_q, w_derr_d;
    logic              w_lerr_q, w_lerr_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              w_we;
    logic              w_last_beat;
    logic              aw_err;
    logic [IDX_W-1:0]  w_idx;
    logic              unused_wid;

    assign aw_err      = burst_err(AWADDR, AWLEN, AWSIZE, AWBURST);
    assign w_last_beat = (w_cnt_q == w_len_q);
    assign w_idx       = w_addr_q[IDX_W+LANE_W-1:LANE_W];
    assign unused_wid  = ^WID;

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_cnt_d   = w_cnt_q;
        w_derr_d  = w_derr_q;
        w_lerr_d  = w_lerr_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        w_we      = 1'b0;
        unique case (w_state_q)
            WIdle: begin
                awready_d = 1'b1;
                if (AWVALID && awready_q) begin
                    w_id_d    = AWID;
                    w_addr_d  = AWADDR;
                    w_len_d   = AWLEN;
                    w_size_d  = AWSIZE;
                    w_burst_d = AWBURST;
                    w_cnt_d   = 4'd0;
                    w_derr_d  = aw_err;
                    w_lerr_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = WData;
                end
            end
            WData: begin
                if (WVALID && wready_q) begin
                    // A bad burst still consumes all beats but never touches memory.
                    w_we     = !w_derr_q;
                    w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
                    w_cnt_d  = w_cnt_q + 4'd1;
                    if (WLAST != w_last_beat) w_lerr_d = 1'b1;
                    if (w_last_beat) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bid_d     = w_id_q;
                        bresp_d   = (w_derr_q || w_lerr_q || !WLAST) ? RespSlverr : RespOkay;
                        w_state_d = WResp;
                    end
                end
            end
            WResp: begin
                if (BREADY && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    bid_d     = '0;
                    bresp_d   = RespOkay;
                    awready_d = 1'b1;
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q <= WIdle;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_cnt_q   <= '0;
            w_derr_q  <= 1'b0;
            w_lerr_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_cnt_q   <= w_cnt_d;
            w_derr_q  <= w_derr_d;
            w_lerr_q  <= w_lerr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Memory has no reset; contents survive ARESETn.
    always_ff @(posedge ACLK) begin
        if (w_we) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (WSTRB[b]) mem_q[w_idx][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    // ---------------------------------------------------------------- read side
    r_state_e          r_state_q, r_state_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [3:0]        r_len_q, r_len_d;
    logic [2:0]        r_size_q, r_size_d;
    logic [1:0]        r_burst_q, r_burst_d;
    logic [3:0]        r_cnt_q, r_cnt_d;
    logic              r_err_q, r_err_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rlast_q, rlast_d;
    logic              ar_err;
    logic [IDX_W-1:0]  ar_idx;
    logic [IDX_W-1:0]  r_idx;

    assign ar_err = burst_err(ARADDR, ARLEN, ARSIZE, ARBURST);
    assign ar_idx = ARADDR[IDX_W+LANE_W-1:LANE_W];
    assign r_idx  = r_addr_q[IDX_W+LANE_W-1:LANE_W];

    // Data is sampled from memory before the clock edge, so a same-cycle write is not seen.
    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        r_err_d   = r_err_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        unique case (r_state_q)
            RIdle: begin
                arready_d = 1'b1;
                if (ARVALID && arready_q) begin
                    r_addr_d  = next_addr(ARADDR, ARLEN, ARSIZE, ARBURST);
                    r_len_d   = ARLEN;
                    r_size_d  = ARSIZE;
                    r_burst_d = ARBURST;
                    r_cnt_d   = 4'd1;
                    r_err_d   = ar_err;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rid_d     = ARID;
                    rdata_d   = ar_err ? '0 : mem_q[ar_idx];
                    rresp_d   = ar_err ? RespSlverr : RespOkay;
                    rlast_d   = (ARLEN == 4'd0);
                    r_state_d = RData;
                end
            end
            RData: begin
                if (RREADY && rvalid_q) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rid_d     = '0;
                        rdata_d   = '0;
                        rresp_d   = RespOkay;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = RIdle;
                    end else begin
                        rdata_d  = r_err_q ? '0 : mem_q[r_idx];
                        rlast_d  = (r_cnt_q == r_len_q);
                        r_addr_d = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
                        r_cnt_d  = r_cnt_q + 4'd1;
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q <= RIdle;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_cnt_q   <= '0;
            r_err_q   <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_cnt_q   <= r_cnt_d;
            r_err_q   <= r_err_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;

endmodule

// File: tb/tb_axi_modport_slave.sv
// Directed bench for axi_modport_slave: bursts, strobes, error responses, backpressure, reset.
module tb_axi_modport_slave;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b1;
    logic [3:0]  AWID = '0;
    logic [31:0] AWADDR = '0;
    logic [3:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = '0;
    logic [1:0]  AWBURST = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [3:0]  WID = '0;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WLAST = 1'b0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [3:0]  ARID = '0;
    logic [31:0] ARADDR = '0;
    logic [3:0]  ARLEN = '0;
    logic [2:0]  ARSIZE = '0;
    logic [1:0]  ARBURST = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id   [16];

    always #5 ACLK = ~ACLK;

    axi_modport_slave dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic rdy;
        bit   done = 0;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            rdy = AWREADY;
            @(posedge ACLK); #1;
            if (rdy) done = 1;
        end
        AWVALID = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL aw_timeout: AWREADY=%b required 1", AWREADY);
        end
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        logic rdy;
        bit   done = 0;
        WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            rdy = WREADY;
            @(posedge ACLK); #1;
            if (rdy) done = 1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL w_timeout: WREADY=%b required 1", WREADY);
        end
    endtask

    task automatic get_b(output logic [1:0] resp, output logic [3:0] id);
        logic v;
        bit   done = 0;
        resp = 2'bxx; id = 4'bxxxx;
        BREADY = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            v = BVALID;
            if (v) begin resp = BRESP; id = BID; end
            @(posedge ACLK); #1;
            if (v) done = 1;
        end
        BREADY = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL b_timeout: BVALID=%b required 1", BVALID);
        end
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic rdy;
        bit   done = 0;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            rdy = ARREADY;
            @(posedge ACLK); #1;
            if (rdy) done = 1;
        end
        ARVALID = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL ar_timeout: ARREADY=%b required 1", ARREADY);
        end
    endtask

    task automatic recv_r(input logic [3:0] len);
        logic v;
        bit   done;
        RREADY = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            done = 0;
            for (int n = 0; n < 50 && !done; n++) begin
                v = RVALID;
                if (v) begin
                    rd_data[b] = RDATA; rd_resp[b] = RRESP; rd_last[b] = RLAST; rd_id[b] = RID;
                end
                @(posedge ACLK); #1;
                if (v) done = 1;
            end
            if (!done) begin
                checks++; errors++;
                $display("FAIL r_timeout: beat %0d RVALID=%b required 1", b, RVALID);
            end
        end
        RREADY = 1'b0;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        checks++;
        if ({AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RID, RDATA, RRESP, RLAST} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: AWREADY=%b ARREADY=%b BVALID=%b RVALID=%b required all 0",
                     AWREADY, ARREADY, BVALID, RVALID);
        end
        ARESETn = 1'b1;
        checks++;
        if ({AWREADY, ARREADY} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release_ready: got %b%b required 00", AWREADY, ARREADY);
        end
        @(posedge ACLK); #1;
        checks++;
        if ({AWREADY, ARREADY} !== 2'b11) begin
            errors++;
            $display("FAIL ready_after_reset: got %b%b required 11", AWREADY, ARREADY);
        end
    endtask

    task automatic test_single();
        logic [1:0] resp;
        logic [3:0] id;
        send_aw(4'd3, 32'h10, 4'd0, 3'd2, 2'd1);
        send_w(32'hDEADBEEF, 4'hF, 1'b1);
        get_b(resp, id);
        checks++;
        if (resp !== 2'b00) begin errors++; $display("FAIL single_bresp: got %b required 00", resp); end
        checks++;
        if (id !== 4'd3) begin errors++; $display("FAIL single_bid: got %0d required 3", id); end
        send_ar(4'd5, 32'h10, 4'd0, 3'd2, 2'd1);
        recv_r(4'd0);
        checks++;
        if (rd_data[0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_rdata: got %h required deadbeef", rd_data[0]);
        end
        checks++;
        if ({rd_last[0], rd_resp[0], rd_id[0]} !== {1'b1, 2'b00, 4'd5}) begin
            errors++;
            $display("FAIL single_rmeta: last=%b resp=%b id=%0d required 1/00/5",
                     rd_last[0], rd_resp[0], rd_id[0]);
        end
    endtask

    task automatic test_incr();
        logic [1:0] resp;
        logic [3:0] id;
        send_aw(4'd1, 32'h100, 4'd3, 3'd2, 2'd1);
        for (int b = 0; b < 4; b++) send_w(32'(b + 1), 4'hF, b == 3);
        get_b(resp, id);
        checks++;
        if (resp !== 2'b00) begin errors++; $display("FAIL incr_bresp: got %b required 00", resp); end
        send_ar(4'd2, 32'h100, 4'd3, 3'd2, 2'd1);
        recv_r(4'd3);
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (rd_data[b] !== 32'(b + 1) || rd_last[b] !== (b == 3)) begin
                errors++;
                $display("FAIL incr_beat%0d: data=%h last=%b required %h last=%b",
                         b, rd_data[b], rd_last[b], 32'(b + 1), b == 3);
            end
        end
    endtask

    task automatic test_wrap();
        logic [1:0] resp;
        logic [3:0] id;
        send_aw(4'd4, 32'h38, 4'd3, 3'd2, 2'd2);
        for (int b = 0; b < 4; b++) send_w(32'hA000_0000 + 32'(b), 4'hF, b == 3);
        get_b(resp, id);
        checks++;
        if (resp !== 2'b00) begin errors++; $display("FAIL wrap_bresp: got %b required 00", resp); end
        send_ar(4'd4, 32'h38, 4'd3, 3'd2, 2'd2);
        recv_r(4'd3);
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (rd_data[b] !== 32'hA000_0000 + 32'(b) || rd_resp[b] !== 2'b00) begin
                errors++;
                $display("FAIL wrap_beat%0d: data=%h resp=%b required %h resp=00",
                         b, rd_data[b], rd_resp[b], 32'hA000_0000 + 32'(b));
            end
        end
        // third write beat wrapped to the bottom of the 16-byte window
        send_ar(4'd0, 32'h30, 4'd0, 3'd2, 2'd1);
        recv_r(4'd0);
        checks++;
        if (rd_data[0] !== 32'hA000_0002) begin
            errors++; $display("FAIL wrap_addr_0x30: got %h required a0000002", rd_data[0]);
        end
    endtask

    task automatic test_fixed();
        logic [1:0] resp;
        logic [3:0] id;
        send_aw(4'd7, 32'h400, 4'd1, 3'd2, 2'd0);
        send_w(32'h5, 4'hF, 1'b0);
        send_w(32'h6, 4'hF, 1'b1);
        get_b(resp, id);
        send_ar(4'd7, 32'h400, 4'd1, 3'd2, 2'd0);
        recv_r(4'd1);
        checks++;
        if (rd_data[0] !== 32'h6 || rd_data[1] !== 32'h6 || rd_last[1] !== 1'b1) begin
            errors++;
            $display("FAIL fixed_read: got %h %h last=%b required 6 6 last=1",
                     rd_data[0], rd_data[1], rd_last[1]);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp;
        logic [3:0] id;
        send_aw(4'd0, 32'h200, 4'd0, 3'd2, 2'd1); send_w(32'h0, 4'hF, 1'b1); get_b(resp, id);
        send_aw(4'd0, 32'h200, 4'd0, 3'd2, 2'd1); send_w(32'hAABBCCDD, 4'b0101, 1'b1); get_b(resp, id);
        send_ar(4'd0, 32'h200, 4'd0, 3'd2, 2'd1); recv_r(4'd0);
        checks++;
        if (rd_data[0] !== 32'h00BB00DD) begin
            errors++; $display("FAIL strobe_0101: got %h required 00bb00dd", rd_data[0]);
        end
        send_aw(4'd0, 32'h201, 4'd0, 3'd0, 2'd1); send_w(32'h0000EE00, 4'b0010, 1'b1); get_b(resp, id);
        checks++;
        if (resp !== 2'b00) begin errors++; $display("FAIL narrow_bresp: got %b required 00", resp); end
        send_ar(4'd0, 32'h200, 4'd0, 3'd2, 2'd1); recv_r(4'd0);
        checks++;
        if (rd_data[0] !== 32'h00BBEEDD) begin
            errors++; $display("FAIL narrow_byte1: got %h required 00bbeedd", rd_data[0]);
        end
    endtask

    task automatic test_errors();
        logic [1:0] resp;
        logic [3:0] id;
        send_aw(4'd9, 32'h10, 4'd0, 3'd2, 2'd3); send_w(32'h12345678, 4'hF, 1'b1); get_b(resp, id);
        checks++;
        if ({resp, id} !== {2'b10, 4'd9}) begin
            errors++; $display("FAIL burst3_bresp: resp=%b id=%0d required 10 id=9", resp, id);
        end
        send_ar(4'd0, 32'h10, 4'd0, 3'd2, 2'd1); recv_r(4'd0);
        checks++;
        if (rd_data[0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL burst3_mem: got %h required deadbeef", rd_data[0]);
        end
        send_ar(4'd6, 32'h100, 4'd2, 3'd2, 2'd2); recv_r(4'd2);
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (rd_data[b] !== 32'h0 || rd_resp[b] !== 2'b10 || rd_last[b] !== (b == 2)) begin
                errors++;
                $display("FAIL wraplen2_beat%0d: data=%h resp=%b last=%b required 0/10/%b",
                         b, rd_data[b], rd_resp[b], rd_last[b], b == 2);
            end
        end
        send_ar(4'd1, 32'h10, 4'd0, 3'd3, 2'd1); recv_r(4'd0);
        checks++;
        if (rd_data[0] !== 32'h0 || rd_resp[0] !== 2'b10) begin
            errors++;
            $display("FAIL size3_read: data=%h resp=%b required 0/10", rd_data[0], rd_resp[0]);
        end
        send_aw(4'd2, 32'h102, 4'd1, 3'd2, 2'd2);
        send_w(32'hBAD0, 4'hF, 1'b0); send_w(32'hBAD1, 4'hF, 1'b1);
        get_b(resp, id);
        checks++;
        if (resp !== 2'b10) begin errors++; $display("FAIL wrap_misalign: got %b required 10", resp); end
        send_ar(4'd0, 32'h100, 4'd0, 3'd2, 2'd1); recv_r(4'd0);
        checks++;
        if (rd_data[0] !== 32'h1) begin
            errors++; $display("FAIL misalign_mem: got %h required 00000001", rd_data[0]);
        end
        send_aw(4'd3, 32'h700, 4'd0, 3'd2, 2'd1); send_w(32'h77, 4'hF, 1'b0); get_b(resp, id);
        checks++;
        if (resp !== 2'b10) begin errors++; $display("FAIL wlast_missing: got %b required 10", resp); end
    endtask

    task automatic test_backpressure();
        logic [1:0] resp;
        logic [3:0] id;
        send_aw(4'd6, 32'h600, 4'd1, 3'd2, 2'd1);
        send_w(32'h11111111, 4'hF, 1'b0);
        send_w(32'h22222222, 4'hF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({BVALID, BID, BRESP} !== {1'b1, 4'd6, 2'b00}) begin
                errors++;
                $display("FAIL b_stall%0d: valid=%b id=%0d resp=%b required 1/6/00",
                         i, BVALID, BID, BRESP);
            end
            @(posedge ACLK); #1;
        end
        get_b(resp, id);
        checks++;
        if (BVALID !== 1'b0) begin errors++; $display("FAIL b_release: BVALID=%b required 0", BVALID); end
        send_ar(4'd9, 32'h600, 4'd1, 3'd2, 2'd1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({RVALID, RID, RDATA, RRESP, RLAST} !== {1'b1, 4'd9, 32'h11111111, 2'b00, 1'b0}) begin
                errors++;
                $display("FAIL r_stall%0d: valid=%b id=%0d data=%h resp=%b last=%b required 1/9/11111111/00/0",
                         i, RVALID, RID, RDATA, RRESP, RLAST);
            end
            @(posedge ACLK); #1;
        end
        RREADY = 1'b1;
        @(posedge ACLK); #1;
        checks++;
        if ({RVALID, RDATA, RLAST} !== {1'b1, 32'h22222222, 1'b1}) begin
            errors++;
            $display("FAIL r_beat1: valid=%b data=%h last=%b required 1/22222222/1", RVALID, RDATA, RLAST);
        end
        @(posedge ACLK); #1;
        RREADY = 1'b0;
        checks++;
        if (RVALID !== 1'b0) begin errors++; $display("FAIL r_end: RVALID=%b required 0", RVALID); end
    endtask

    task automatic test_reset_mid_burst();
        send_aw(4'd5, 32'h300, 4'd3, 3'd2, 2'd1);
        send_w(32'h11, 4'hF, 1'b0);
        send_w(32'h22, 4'hF, 1'b0);
        send_ar(4'd8, 32'h10, 4'd0, 3'd2, 2'd1);
        checks++;
        if ({WREADY, RVALID} !== 2'b11) begin
            errors++; $display("FAIL mid_burst_busy: WREADY=%b RVALID=%b required 1 1", WREADY, RVALID);
        end
        ARESETn = 1'b0;
        #1;
        checks++;
        if ({AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RID, RDATA, RRESP, RLAST} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: WREADY=%b RVALID=%b RID=%0d RDATA=%h required all 0",
                     WREADY, RVALID, RID, RDATA);
        end
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        checks++;
        if ({AWREADY, ARREADY, WREADY} !== 3'b110) begin
            errors++;
            $display("FAIL mid_reset_idle: AWREADY=%b ARREADY=%b WREADY=%b required 1 1 0",
                     AWREADY, ARREADY, WREADY);
        end
        send_ar(4'd0, 32'h300, 4'd1, 3'd2, 2'd1);
        recv_r(4'd1);
        checks++;
        if (rd_data[0] !== 32'h11 || rd_data[1] !== 32'h22) begin
            errors++;
            $display("FAIL partial_beats: got %h %h required 11 22", rd_data[0], rd_data[1]);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_single();
        test_incr();
        test_wrap();
        test_fixed();
        test_strobe();
        test_errors();
        test_backpressure();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
